// File: rtl/data_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_sync_ctrl_pkg
// Brief    : Shared state encodings, counter widths and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package data_sync_ctrl_pkg;

    localparam int c_xfer_count_w = 8;
    localparam int c_settle_w     = 4;

    localparam logic [c_xfer_count_w-1:0] c_xfer_count_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    function automatic logic [c_xfer_count_w-1:0] sat_inc(
        input logic [c_xfer_count_w-1:0] value
    );
        return (value == c_xfer_count_max) ? value : value + 1'b1;
    endfunction

endpackage : data_sync_ctrl_pkg
`default_nettype wire

// File: rtl/data_sync_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_sync_ctrl_if
// Brief    : Source-side request/data bus and destination-side result signals.
// Revision : 1.0 - initial release
// ============================================================================
interface data_sync_ctrl_if
    import data_sync_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH = 8
);

    logic [BUS_WIDTH-1:0]      unsync_bus;
    logic                      bus_req;
    logic [BUS_WIDTH-1:0]      sync_bus;
    logic                      enable_pulse;
    logic                      ack;
    logic                      abort_pulse;
    logic [c_xfer_count_w-1:0] xfer_count;

    modport master (
        output unsync_bus,
        output bus_req,
        input  sync_bus,
        input  enable_pulse,
        input  ack,
        input  abort_pulse,
        input  xfer_count
    );

    modport slave (
        input  unsync_bus,
        input  bus_req,
        output sync_bus,
        output enable_pulse,
        output ack,
        output abort_pulse,
        output xfer_count
    );

endinterface : data_sync_ctrl_if
`default_nettype wire

// File: rtl/data_sync_ctrl_sync_chain_hr.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain_hr
// Brief    : NUM_STAGES-deep single-bit synchronizer, async active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain_hr #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] r_stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stages <= '0;
        end else begin
            r_stages <= {r_stages[NUM_STAGES-2:0], d};
        end
    end

    assign q = r_stages[NUM_STAGES-1];

endmodule : sync_chain_hr
`default_nettype wire

// File: rtl/data_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_sync_ctrl
// Brief    : 4-phase req/ack bus synchronizer with settle delay and abort detect.
// Revision : 1.0 - initial release
// ============================================================================
module data_sync_ctrl
    import data_sync_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH     = 8,
    parameter int NUM_STAGES    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    data_sync_ctrl_if.slave  bus
);

    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES - 1);

    logic                      w_req_s;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [c_settle_w-1:0]     r_cnt;
    logic [c_settle_w-1:0]     w_cnt_next;
    logic [BUS_WIDTH-1:0]      r_sync_bus;
    logic [BUS_WIDTH-1:0]      w_sync_bus_next;
    logic                      r_enable_pulse;
    logic                      w_enable_pulse_next;
    logic                      r_abort_pulse;
    logic                      w_abort_pulse_next;
    logic                      r_ack;
    logic                      w_ack_next;
    logic [c_xfer_count_w-1:0] r_xfer_count;
    logic [c_xfer_count_w-1:0] w_xfer_count_next;

    sync_chain_hr #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.bus_req),
        .q     (w_req_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_sync_bus     <= '0;
            r_enable_pulse <= 1'b0;
            r_abort_pulse  <= 1'b0;
            r_ack          <= 1'b0;
            r_xfer_count   <= '0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_sync_bus     <= w_sync_bus_next;
            r_enable_pulse <= w_enable_pulse_next;
            r_abort_pulse  <= w_abort_pulse_next;
            r_ack          <= w_ack_next;
            r_xfer_count   <= w_xfer_count_next;
        end
    end

    // All outputs are computed one edge ahead so they leave the block straight from flops.
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_sync_bus_next     = r_sync_bus;
        w_enable_pulse_next = 1'b0;
        w_abort_pulse_next  = 1'b0;
        w_ack_next          = r_ack;
        w_xfer_count_next   = r_xfer_count;

        case (r_state)
            ST_IDLE: begin
                w_ack_next = 1'b0;
                if (w_req_s) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = c_settle_load;
                end
            end

            ST_SETTLE: begin
                if (!w_req_s) begin
                    w_abort_pulse_next = 1'b1;
                    w_ack_next         = 1'b0;
                    w_cnt_next         = '0;
                    w_state_next       = ST_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_sync_bus_next     = bus.unsync_bus;
                    w_enable_pulse_next = 1'b1;
                    w_ack_next          = 1'b1;
                    w_xfer_count_next   = sat_inc(r_xfer_count);
                    w_state_next        = ST_ACK;
                end
            end

            ST_ACK: begin
                w_ack_next = 1'b1;
                if (!w_req_s) begin
                    w_ack_next   = 1'b0;
                    w_state_next = ST_WAIT_LOW;
                end
            end

            // One guaranteed low-ack cycle; a request seen here waits for IDLE.
            ST_WAIT_LOW: begin
                w_ack_next   = 1'b0;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_ack_next   = 1'b0;
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.sync_bus     = r_sync_bus;
    assign bus.enable_pulse = r_enable_pulse;
    assign bus.abort_pulse  = r_abort_pulse;
    assign bus.ack          = r_ack;
    assign bus.xfer_count   = r_xfer_count;

endmodule : data_sync_ctrl
`default_nettype wire

// File: tb/tb_data_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sync_ctrl
// Brief    : Self-checking bench; expectations from an edge-indexed handshake model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sync_ctrl;

    localparam int BW   = 8;
    localparam int NS   = 2;
    localparam int S    = 2;
    localparam int MAXE = 4096;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    data_sync_ctrl_if #(.BUS_WIDTH(BW)) bus_if ();

    data_sync_ctrl #(
        .BUS_WIDTH     (BW),
        .NUM_STAGES    (NS),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus per edge index, and expected output values just after that edge.
    bit        req_at  [MAXE];
    logic [7:0] data_at [MAXE];
    bit        exp_en  [MAXE];
    bit        exp_ab  [MAXE];
    bit        exp_ack [MAXE];
    logic [7:0] exp_bus [MAXE];
    int        exp_cnt [MAXE];
    int        pos;
    int        first_en;
    int        en_seen;
    int        ab_seen;
    int        en_expected;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < MAXE; i++) begin
            req_at[i]  = 1'b0;
            data_at[i] = 8'h00;
        end
        pos = 0;
    endtask

    // Request high for h sampled edges, then low for l; data held over both.
    task automatic add_req(input int h, input int l, input logic [7:0] d);
        for (int i = 0; i < h + l; i++) begin
            req_at[pos + i]  = (i < h);
            data_at[pos + i] = d;
        end
        pos += h + l;
    endtask

    // A request seen for edges [a+NS, a+h+NS-1] starts once the controller is free;
    // it captures if it survives S more edges, otherwise it aborts on the first low edge.
    task automatic build_model(input int n);
        int k, a, h, st, cap, drop, fr, cnt;
        logic [7:0] bus_v;
        for (int i = 0; i < MAXE; i++) begin
            exp_en[i]  = 1'b0;
            exp_ab[i]  = 1'b0;
            exp_ack[i] = 1'b0;
        end
        fr = 0;
        k  = 0;
        while (k < n) begin
            if (req_at[k]) begin
                a = k;
                h = 0;
                while (k < n && req_at[k]) begin
                    h++;
                    k++;
                end
                st = (a + NS > fr) ? a + NS : fr;
                if (st <= a + h + NS - 1) begin
                    cap  = st + S;
                    drop = a + h + NS;
                    if (cap <= a + h + NS - 1) begin
                        if (cap < n) exp_en[cap] = 1'b1;
                        for (int j = cap; j < drop && j < n; j++) exp_ack[j] = 1'b1;
                        fr = drop + 2;
                    end else begin
                        if (drop < n) exp_ab[drop] = 1'b1;
                        fr = drop + 1;
                    end
                end
            end else begin
                k++;
            end
        end
        bus_v = 8'h00;
        cnt   = 0;
        en_expected = 0;
        for (int i = 0; i < n; i++) begin
            if (exp_en[i]) begin
                bus_v = data_at[i];
                if (cnt < 255) cnt++;
                en_expected++;
            end
            exp_bus[i] = bus_v;
            exp_cnt[i] = cnt;
        end
    endtask

    task automatic run_phase(input int n);
        build_model(n);
        first_en = -1;
        en_seen  = 0;
        ab_seen  = 0;
        for (int k = 0; k < n; k++) begin
            bus_if.bus_req    = req_at[k];
            bus_if.unsync_bus = data_at[k];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("enable_pulse@%0d", k), {31'd0, bus_if.enable_pulse}, {31'd0, exp_en[k]});
            check($sformatf("abort_pulse@%0d", k),  {31'd0, bus_if.abort_pulse},  {31'd0, exp_ab[k]});
            check($sformatf("ack@%0d", k),          {31'd0, bus_if.ack},          {31'd0, exp_ack[k]});
            check($sformatf("sync_bus@%0d", k),     {24'd0, bus_if.sync_bus},     {24'd0, exp_bus[k]});
            check($sformatf("xfer_count@%0d", k),   {24'd0, bus_if.xfer_count},   exp_cnt[k]);
            check($sformatf("pulse_overlap@%0d", k),
                  {31'd0, bus_if.enable_pulse & bus_if.abort_pulse}, 32'd0);
            if (bus_if.enable_pulse && first_en < 0) first_en = k;
            if (bus_if.enable_pulse) en_seen++;
            if (bus_if.abort_pulse)  ab_seen++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sync_bus"},     {24'd0, bus_if.sync_bus},   32'd0);
        check({tag, "_enable_pulse"}, {31'd0, bus_if.enable_pulse}, 32'd0);
        check({tag, "_abort_pulse"},  {31'd0, bus_if.abort_pulse},  32'd0);
        check({tag, "_ack"},          {31'd0, bus_if.ack},          32'd0);
        check({tag, "_xfer_count"},   {24'd0, bus_if.xfer_count},   32'd0);
    endtask

    // Asserted between clock edges so only an asynchronous reset clears outputs by the check.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check_all_zero(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus_if.bus_req    = 1'b0;
        bus_if.unsync_bus = 8'h00;
        reset             = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_init");
        reset = 1'b0;

        // Nominal capture + close, single-cycle abort, back-to-back 11 then 22.
        clear_sched();
        add_req(8, 6, 8'hA5);
        add_req(1, 6, 8'h77);
        add_req(6, 1, 8'h11);
        add_req(6, 6, 8'h22);
        run_phase(pos);
        check("nominal_latency",  first_en, NS + S);
        check("directed_enables", en_seen, 3);
        check("directed_aborts",  ab_seen, 1);
        check("directed_last_bus", {24'd0, bus_if.sync_bus}, 32'h22);
        check("directed_count",   {24'd0, bus_if.xfer_count}, 32'd3);
        check("directed_ack_low", {31'd0, bus_if.ack}, 32'd0);

        // Randomized requests of mixed length, then enough full transfers to saturate.
        @(negedge clk);
        apply_reset("reset_pre_random");
        clear_sched();
        for (int i = 0; i < 40; i++) begin
            add_req($urandom_range(6, 1), $urandom_range(5, 1), 8'($urandom));
        end
        for (int i = 0; i < 260; i++) begin
            add_req(3, 2, 8'($urandom));
        end
        add_req(0, 8, 8'h00);
        run_phase(pos);
        check("random_enable_total", en_seen, en_expected);
        check("saturated_count", {24'd0, bus_if.xfer_count}, 32'd255);

        // Reset while acknowledging 3C, bus_req still high, then a fresh capture.
        @(negedge clk);
        apply_reset("reset_pre_midack");
        clear_sched();
        add_req(12, 0, 8'h3C);
        run_phase(pos);
        check("midack_ack_high", {31'd0, bus_if.ack}, 32'd1);
        check("midack_bus",      {24'd0, bus_if.sync_bus}, 32'h3C);
        apply_reset("reset_midack");
        clear_sched();
        add_req(10, 6, 8'h3C);
        run_phase(pos);
        check("post_reset_latency", first_en, NS + S);
        check("post_reset_count",   {24'd0, bus_if.xfer_count}, 32'd1);
        check("post_reset_bus",     {24'd0, bus_if.sync_bus}, 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_sync_ctrl
`default_nettype wire
